sr_ignition_monitor: RTL and testbench
======================================

# sr_ignition_monitor

Passive observer on the output side of the SIE ignition controller. It samples `ignition_phase`, `gain_envelope` and `plv_envelope` on every `clk_en` cycle, checks that the phase sequence is legal, and measures each ignition event: coherence-first lead, peak gain and active duration. Each completed event becomes a record in a small FIFO, which the host/telemetry side drains with a valid/ready handshake.

## Interface
Parameters:
- `WIDTH`, 18: envelope width, signed.
- `FRAC`, 14: fractional bits (Q14).
- `DEPTH`, 4: record FIFO depth; power of two, 2–16.
- `PLV_MARK`, 11469: PLV crossing level (0.70 in Q14).
- `GAIN_MARK`, 8192: gain crossing level (0.50 in Q14).

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `clk_en`  in  1: 4 kHz sample strobe; gates all monitoring logic.
- `ignition_phase`  in  3: observed phase, 0–6 legal.
- `gain_envelope`  in  WIDTH signed: observed gain.
- `plv_envelope`  in  WIDTH signed: observed PLV.
- `rec_valid`  out  1: FIFO head record valid.
- `rec_ready`  in  1: consumer accepts the head record.
- `rec_lead`  out  16: gain-cross count minus PLV-cross count, saturating.
- `rec_peak_gain`  out  WIDTH signed: maximum gain seen during the event.
- `rec_active`  out  20: `clk_en` cycles spent in phases 1–5, saturating.
- `rec_flags`  out  3: {`seq_error`, `no_gain_cross`, `gain_first`}.
- `event_count`  out  16: records pushed (wraps).
- `drop_count`  out  8: records lost to a full FIFO (saturates at 255).
- `seq_error`  out  1: one-`clk` pulse on an illegal transition.

## Operation
- All tracking updates only when `clk_en`=1. Previous phase `prev_ph` is registered; reset value is 0.
- Legal phase changes: 0→1, 1→2, 2→3, 3→4, 4→5, 5→6, 6→0. Holding the same phase is legal.
- Any other change, including any value of 7, is illegal: pulse `seq_error`.
- FSM states: `IDLE`, `TRACK`, `COOL`.
- **IDLE**
  - On 0→1: clear the trackers and go to `TRACK`.
  - Any other non-zero phase seen here is `seq_error`; stay in `IDLE` and write no record.
- **TRACK** (phases 1–5)
  - `active_cnt`: +1 per `clk_en`, saturating at 0xFFFFF.
  - `peak` = max(`peak`, `gain_envelope`).
  - `plv_t`: latches `active_cnt` on the first cycle `plv_envelope` ≥ `PLV_MARK`.
  - `gain_t`: latches `active_cnt` on the first cycle `gain_envelope` ≥ `GAIN_MARK`.
  - Comparisons are signed.
  - On 5→6: push a record and go to `COOL`.
  - On an illegal change: push a record with `seq_error`=1 and go to `IDLE`.
- **COOL** (phase 6)
  - On 6→0: go to `IDLE`.
  - On an illegal change: `seq_error` pulse only, no record; go to `IDLE`.
- Record fields:
  - `lead` = `gain_t` − `plv_t` if both latched and `gain_t` > `plv_t`, saturated to 0xFFFF.
  - Otherwise `lead` = 0, and `gain_first`=1 when `gain_t` ≤ `plv_t`.
  - `no_gain_cross`=1 if `gain_t` never latched.
  - If `plv_t` never latched and gain did cross, `gain_first`=1.
- FIFO:
  - Push is a single-cycle write. Pop is `rec_valid & rec_ready`, independent of `clk_en`.
  - Push while full without a same-cycle pop: record dropped, `drop_count`+1.
  - Push and pop in the same cycle while full: both succeed.
  - Pop while empty: ignored.
- `event_count` increments on every attempted push, dropped or not.

## Timing
- Reset values: `rec_valid`=0, all `rec_*`=0, `event_count`=0, `drop_count`=0, `seq_error`=0. FSM in `IDLE`, all trackers 0, FIFO empty.
- Transition detection: the transition is visible on the `clk_en` cycle where `ignition_phase` ≠ `prev_ph`. The push occurs at that same `clk` edge.
- `rec_valid` rises on the following `clk` edge if the FIFO was empty, i.e. 1-cycle latency.
- `rec_*` are registered from the FIFO head and are stable while `rec_valid`=1 and `rec_ready`=0.
- The next record appears the cycle after a pop.
- `seq_error` is high for exactly one `clk`, registered, on the detecting edge.
- Asynchronous reset mid-event discards the trackers and FIFO contents immediately; monitoring resumes on the next 0→1.

## Structure
- Shared package `sr_ignition_pkg` holds:
  - phase encodings `PH_BASELINE` … `PH_REFRACTORY`;
  - Q14 constants;
  - packed record type `sie_rec_t` {`lead`, `peak`, `active`, `flags`}.
- Sub-module `sr_event_fifo`: synchronous FIFO of `sie_rec_t` with `DEPTH`, `push`/`pop`/`full`/`empty`, and registered head.

## Test plan
- **Nominal event.** Stimulus:
  - Phases 1/2/3/4/5/6 held for 100/50/50/200/80/40 `clk_en` cycles, then phase 0.
  - PLV reaches 11469 at `active_cnt`=40; gain reaches 8192 at 130 and peaks at 16384.
  - Required: one record with `lead`=90, `peak`=16384, `active`=480, `flags`=000, and `event_count`=1.
- **Gain first.** Gain crosses at 20 and PLV at 60 → `lead`=0, `flags`=001.
- **Gain never crosses.** Gain stays ≤ 8000 → `flags`=010 and `lead`=0.
- **Illegal skip.** 2→4 mid-event → `seq_error` pulse, record with `flags`[2]=1, FSM in `IDLE`. A following 4→5 produces no record.
- **FIFO overflow.** With `DEPTH`=4, run 6 events with `rec_ready`=0 → `event_count`=6, `drop_count`=2. Then hold `rec_ready`=1 → 4 records pop in order, with `rec_valid` low after the 4th.
- **Reset mid-event.** Assert `rst` during phase 3 → all outputs 0 at once. A fresh full event then yields a correct single record.

Source files
------------

// File: rtl/sr_ignition_pkg.sv
// Shared definitions for the SIE ignition monitor: phase encodings, Q14 levels,
// the event record layout and the record-building helper.
package sr_ignition_pkg;

   localparam logic [2:0] PH_BASELINE   = 3'd0;
   localparam logic [2:0] PH_ARM        = 3'd1;
   localparam logic [2:0] PH_PRIME      = 3'd2;
   localparam logic [2:0] PH_BUILD      = 3'd3;
   localparam logic [2:0] PH_IGNITE     = 3'd4;
   localparam logic [2:0] PH_SUSTAIN    = 3'd5;
   localparam logic [2:0] PH_REFRACTORY = 3'd6;

   localparam int Q14_FRAC      = 14;
   localparam int Q14_ONE       = 1 << Q14_FRAC;
   localparam int Q14_PLV_MARK  = 11469;  // 0.70
   localparam int Q14_GAIN_MARK = 8192;   // 0.50

   localparam int PEAK_W   = 18;
   localparam int LEAD_W   = 16;
   localparam int ACTIVE_W = 20;
   localparam int FLAGS_W  = 3;

   // flags = {seq_error, no_gain_cross, gain_first}
   typedef struct packed {
      logic [LEAD_W-1:0]          lead;
      logic signed [PEAK_W-1:0]   peak;
      logic [ACTIVE_W-1:0]        active;
      logic [FLAGS_W-1:0]         flags;
   } sie_rec_t;

   // Holding a phase, stepping forward by one, or wrapping 6->0 is legal.
   function automatic logic phase_step_legal(input logic [2:0] prev, input logic [2:0] cur);
      logic ok;
      ok = (cur == prev)
         || ((prev <= PH_SUSTAIN) && (cur == prev + 3'd1))
         || ((prev == PH_REFRACTORY) && (cur == PH_BASELINE));
      return ok;
   endfunction

   function automatic sie_rec_t make_rec(
      input logic                     gain_hit,
      input logic                     plv_hit,
      input logic [ACTIVE_W-1:0]      gain_t,
      input logic [ACTIVE_W-1:0]      plv_t,
      input logic signed [PEAK_W-1:0] peak,
      input logic [ACTIVE_W-1:0]      active,
      input logic                     seq_err
   );
      sie_rec_t            r;
      logic [ACTIVE_W-1:0] diff;
      diff     = gain_t - plv_t;
      r.peak   = peak;
      r.active = active;
      r.lead   = '0;
      if (gain_hit && plv_hit && (gain_t > plv_t)) begin
         if (|diff[ACTIVE_W-1:LEAD_W]) r.lead = '1;
         else                          r.lead = diff[LEAD_W-1:0];
      end
      // A missing PLV crossing with a gain crossing also counts as gain-first.
      r.flags = {seq_err, ~gain_hit, gain_hit & (~plv_hit | (gain_t <= plv_t))};
      return r;
   endfunction

endpackage

// File: rtl/sr_event_fifo.sv
// Record FIFO with a registered head. Capacity is DEPTH records including the
// one shown at the head; after a pop the next record is shown one cycle later.
module sr_event_fifo
   import sr_ignition_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     push,
   input  sie_rec_t push_rec,
   input  logic     pop,
   output logic     full,
   output logic     empty,
   output logic     head_valid,
   output sie_rec_t head
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

   sie_rec_t      mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          head_valid_q;
   sie_rec_t      head_q;
   logic          pop_ok, push_ok;

   assign full       = (count_q == DEPTH_CNT);
   assign empty      = (count_q == '0);
   assign pop_ok     = pop & head_valid_q;
   // When full, a push only lands if the head leaves on the same edge.
   assign push_ok    = push & (~full | pop_ok);
   assign head_valid = head_valid_q;
   assign head       = head_q;

   // Storage write; contents are don't-care until counted in.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= push_rec;
   end

   // Pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Head register; drops valid on a pop so the same record is never taken twice.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q       <= '0;
         head_valid_q <= 1'b0;
      end else begin
         head_q       <= mem[rd_ptr_q];
         head_valid_q <= (count_q != '0) && !pop_ok;
      end
   end

endmodule

// File: rtl/sr_ignition_monitor.sv
// Passive monitor for the SIE ignition controller: checks the phase sequence,
// measures each ignition event and queues one record per event.
module sr_ignition_monitor
   import sr_ignition_pkg::*;
#(
   parameter int WIDTH     = 18,
   parameter int FRAC      = Q14_FRAC,
   parameter int DEPTH     = 4,
   parameter int PLV_MARK  = Q14_PLV_MARK,
   parameter int GAIN_MARK = Q14_GAIN_MARK
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clk_en,
   input  logic [2:0]              ignition_phase,
   input  logic signed [WIDTH-1:0] gain_envelope,
   input  logic signed [WIDTH-1:0] plv_envelope,
   output logic                    rec_valid,
   input  logic                    rec_ready,
   output logic [15:0]             rec_lead,
   output logic signed [WIDTH-1:0] rec_peak_gain,
   output logic [19:0]             rec_active,
   output logic [2:0]              rec_flags,
   output logic [15:0]             event_count,
   output logic [7:0]              drop_count,
   output logic                    seq_error
);

   if (WIDTH != PEAK_W || FRAC <= 0 || FRAC >= WIDTH || DEPTH < 2 || DEPTH > 16
       || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
      $error("sr_ignition_monitor: unsupported parameter set");
   end

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_TRACK = 2'd1;
   localparam logic [1:0] ST_COOL  = 2'd2;

   localparam logic signed [WIDTH-1:0] PLV_LVL  = WIDTH'(PLV_MARK);
   localparam logic signed [WIDTH-1:0] GAIN_LVL = WIDTH'(GAIN_MARK);

   logic [1:0]              state_q, state_d;
   logic [2:0]              prev_ph_q;
   logic [ACTIVE_W-1:0]     active_q, active_d;
   logic [ACTIVE_W-1:0]     plv_t_q, plv_t_d, gain_t_q, gain_t_d;
   logic                    plv_hit_q, plv_hit_d, gain_hit_q, gain_hit_d;
   logic signed [WIDTH-1:0] peak_q, peak_d;
   logic                    seq_error_q, seq_err_d;
   logic [15:0]             event_count_q;
   logic [7:0]              drop_count_q;

   logic     changed, legal, plv_cross, gain_cross;
   logic     push, rec_seq_err, pop, fifo_full, fifo_empty;
   sie_rec_t push_rec, head_rec;

   assign changed    = (ignition_phase != prev_ph_q);
   assign legal      = phase_step_legal(prev_ph_q, ignition_phase);
   assign plv_cross  = (plv_envelope >= PLV_LVL);
   assign gain_cross = (gain_envelope >= GAIN_LVL);
   assign push_rec   = make_rec(gain_hit_q, plv_hit_q, gain_t_q, plv_t_q, peak_q, active_q,
                                rec_seq_err);
   // A valid head implies a non-empty FIFO; the empty term is a safety net only.
   assign pop        = rec_valid & rec_ready & ~fifo_empty;

   // Event FSM and trackers; the 0->1 sample is the first tracked sample (count 0).
   always_comb begin
      state_d     = state_q;
      active_d    = active_q;
      plv_t_d     = plv_t_q;
      gain_t_d    = gain_t_q;
      plv_hit_d   = plv_hit_q;
      gain_hit_d  = gain_hit_q;
      peak_d      = peak_q;
      push        = 1'b0;
      rec_seq_err = 1'b0;
      seq_err_d   = 1'b0;
      if (clk_en) begin
         case (state_q)
            ST_IDLE: begin
               if (changed) begin
                  if (prev_ph_q == PH_BASELINE && ignition_phase == PH_ARM) begin
                     state_d    = ST_TRACK;
                     active_d   = ACTIVE_W'(1);
                     peak_d     = gain_envelope;
                     plv_hit_d  = plv_cross;
                     plv_t_d    = '0;
                     gain_hit_d = gain_cross;
                     gain_t_d   = '0;
                  end else if (ignition_phase != PH_BASELINE || !legal) begin
                     seq_err_d = 1'b1;
                  end
               end
            end
            ST_TRACK: begin
               if (changed && prev_ph_q == PH_SUSTAIN && ignition_phase == PH_REFRACTORY) begin
                  push    = 1'b1;
                  state_d = ST_COOL;
               end else if (changed && !legal) begin
                  push        = 1'b1;
                  rec_seq_err = 1'b1;
                  seq_err_d   = 1'b1;
                  state_d     = ST_IDLE;
               end else begin
                  if (active_q != '1) active_d = active_q + ACTIVE_W'(1);
                  if (gain_envelope > peak_q) peak_d = gain_envelope;
                  if (!plv_hit_q && plv_cross) begin
                     plv_hit_d = 1'b1;
                     plv_t_d   = active_q;
                  end
                  if (!gain_hit_q && gain_cross) begin
                     gain_hit_d = 1'b1;
                     gain_t_d   = active_q;
                  end
               end
            end
            ST_COOL: begin
               if (changed) begin
                  state_d = ST_IDLE;
                  if (!legal) seq_err_d = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State, trackers and the registered error pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         prev_ph_q   <= PH_BASELINE;
         active_q    <= '0;
         plv_t_q     <= '0;
         gain_t_q    <= '0;
         plv_hit_q   <= 1'b0;
         gain_hit_q  <= 1'b0;
         peak_q      <= '0;
         seq_error_q <= 1'b0;
      end else begin
         if (clk_en) prev_ph_q <= ignition_phase;
         state_q     <= state_d;
         active_q    <= active_d;
         plv_t_q     <= plv_t_d;
         gain_t_q    <= gain_t_d;
         plv_hit_q   <= plv_hit_d;
         gain_hit_q  <= gain_hit_d;
         peak_q      <= peak_d;
         seq_error_q <= seq_err_d;
      end
   end

   // Push attempts and drops; drop count sticks at its maximum.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         event_count_q <= '0;
         drop_count_q  <= '0;
      end else if (push) begin
         event_count_q <= event_count_q + 16'd1;
         if (fifo_full && !pop && drop_count_q != 8'hFF) drop_count_q <= drop_count_q + 8'd1;
      end
   end

   sr_event_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_rec   (push_rec),
      .pop        (pop),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .head_valid (rec_valid),
      .head       (head_rec)
   );

   assign rec_lead      = head_rec.lead;
   assign rec_peak_gain = head_rec.peak;
   assign rec_active    = head_rec.active;
   assign rec_flags     = head_rec.flags;
   assign event_count   = event_count_q;
   assign drop_count    = drop_count_q;
   assign seq_error     = seq_error_q;

endmodule

// File: tb/tb_sr_ignition_monitor.sv
// Directed bench for sr_ignition_monitor with a record scoreboard.
module tb_sr_ignition_monitor;

   logic               clk;
   logic               rst;
   logic               clk_en;
   logic [2:0]         ignition_phase;
   logic signed [17:0] gain_envelope;
   logic signed [17:0] plv_envelope;
   logic               rec_valid;
   logic               rec_ready;
   logic [15:0]        rec_lead;
   logic signed [17:0] rec_peak_gain;
   logic [19:0]        rec_active;
   logic [2:0]         rec_flags;
   logic [15:0]        event_count;
   logic [7:0]         drop_count;
   logic               seq_error;

   typedef struct {
      int lead;
      int peak;
      int active;
      int flags;
   } exp_t;

   exp_t sb[$];
   int   tests_run    = 0;
   int   tests_failed = 0;
   int   exp_ev       = 0;
   logic se_seen, se_next;

   sr_ignition_monitor dut (
      .clk            (clk),
      .rst            (rst),
      .clk_en         (clk_en),
      .ignition_phase (ignition_phase),
      .gain_envelope  (gain_envelope),
      .plv_envelope   (plv_envelope),
      .rec_valid      (rec_valid),
      .rec_ready      (rec_ready),
      .rec_lead       (rec_lead),
      .rec_peak_gain  (rec_peak_gain),
      .rec_active     (rec_active),
      .rec_flags      (rec_flags),
      .event_count    (event_count),
      .drop_count     (drop_count),
      .seq_error      (seq_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: observed no finish, expected finish before 5 ms");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0d, expected %0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   // One clk_en sample followed by one idle clock.
   task automatic samp(input logic [2:0] ph, input int g, input int p);
      ignition_phase = ph;
      gain_envelope  = g[17:0];
      plv_envelope   = p[17:0];
      clk_en         = 1'b1;
      @(posedge clk); #1;
      se_seen = seq_error;
      clk_en  = 1'b0;
      @(posedge clk); #1;
      se_next = seq_error;
   endtask

   // Phases 1..5 with the given lengths; sample index i counts from the 0->1 sample.
   task automatic run_event(input int l1, input int l2, input int l3, input int l4,
                            input int l5, input int l6, input int px, input int gx,
                            input int lo, input int pk);
      int lens[5];
      int i;
      lens = '{l1, l2, l3, l4, l5};
      i    = 0;
      for (int k = 0; k < 5; k++) begin
         for (int j = 0; j < lens[k]; j++) begin
            samp(3'(k + 1), (i < gx) ? lo : pk, (i < px) ? 5000 : 12000);
            i++;
         end
      end
      for (int j = 0; j < l6; j++) samp(3'd6, 0, 0);
      samp(3'd0, 0, 0);
      samp(3'd0, 0, 0);
   endtask

   task automatic drain_one(input string tag, input bit hold);
      exp_t e;
      for (int i = 0; i < 60 && rec_valid !== 1'b1; i++) begin
         @(posedge clk); #1;
      end
      check({tag, ".valid"}, rec_valid, 1);
      if (sb.size() > 0) e = sb.pop_front();
      else               e = '{-1, -1, -1, -1};
      check({tag, ".lead"}, rec_lead, e.lead);
      check({tag, ".peak"}, rec_peak_gain, e.peak);
      check({tag, ".active"}, rec_active, e.active);
      check({tag, ".flags"}, rec_flags, e.flags);
      rec_ready = 1'b1;
      @(posedge clk); #1;
      if (!hold) rec_ready = 1'b0;
   endtask

   initial begin
      rst            = 1'b1;
      clk_en         = 1'b0;
      ignition_phase = 3'd0;
      gain_envelope  = '0;
      plv_envelope   = '0;
      rec_ready      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset.valid", rec_valid, 0);
      check("reset.lead", rec_lead, 0);
      check("reset.peak", rec_peak_gain, 0);
      check("reset.active", rec_active, 0);
      check("reset.flags", rec_flags, 0);
      check("reset.event_count", event_count, 0);
      check("reset.drop_count", drop_count, 0);
      check("reset.seq_error", seq_error, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Nominal event
      sb.push_back('{90, 16384, 480, 0});
      run_event(100, 50, 50, 200, 80, 40, 40, 130, 1000, 16384);
      exp_ev++;
      drain_one("nominal", 1'b0);
      check("nominal.event_count", event_count, exp_ev);

      // Gain crosses before PLV
      sb.push_back('{0, 12000, 100, 1});
      run_event(20, 20, 20, 20, 20, 5, 60, 20, 1000, 12000);
      exp_ev++;
      drain_one("gain_first", 1'b0);

      // Gain never crosses
      sb.push_back('{0, 8000, 50, 2});
      run_event(10, 10, 10, 10, 10, 5, 5, 1000, 8000, 0);
      exp_ev++;
      drain_one("no_gain", 1'b0);
      check("no_gain.event_count", event_count, exp_ev);

      // Illegal 2->4 skip mid-event
      sb.push_back('{3, 9000, 20, 4});
      for (int i = 0; i < 20; i++)
         samp((i < 10) ? 3'd1 : 3'd2, (i < 5) ? 1000 : 9000, (i < 2) ? 5000 : 12000);
      samp(3'd4, 0, 0);
      exp_ev++;
      check("skip.seq_error", se_seen, 1);
      check("skip.seq_error_width", se_next, 0);
      repeat (3) samp(3'd4, 0, 0);
      repeat (3) samp(3'd5, 0, 0);
      repeat (2) samp(3'd0, 0, 0);
      drain_one("skip", 1'b0);
      repeat (10) @(posedge clk);
      #1;
      check("skip.no_extra_record", rec_valid, 0);
      check("skip.event_count", event_count, exp_ev);

      // Overflow: six events into a four-deep FIFO with the consumer stalled
      for (int k = 0; k < 6; k++) begin
         if (k < 4) sb.push_back('{1, 9000 + k, 5 * (k + 2), 0});
         run_event(k + 2, k + 2, k + 2, k + 2, k + 2, 2, 0, 1, 0, 9000 + k);
         exp_ev++;
      end
      check("overflow.event_count", event_count, exp_ev);
      check("overflow.drop_count", drop_count, 2);
      check("overflow.head_waiting", rec_valid, 1);
      rec_ready = 1'b1;
      for (int k = 0; k < 4; k++) drain_one($sformatf("overflow.rec%0d", k), 1'b1);
      repeat (5) @(posedge clk);
      #1;
      check("overflow.empty_after_drain", rec_valid, 0);
      rec_ready = 1'b0;

      // Reset mid-event discards a queued record and the partial event
      sb.push_back('{1, 9100, 10, 0});
      run_event(2, 2, 2, 2, 2, 2, 0, 1, 0, 9100);
      exp_ev++;
      check("rst.pre_valid", rec_valid, 1);
      for (int i = 0; i < 8; i++)
         samp((i < 3) ? 3'd1 : ((i < 6) ? 3'd2 : 3'd3), 9000, 12000);
      #3 rst = 1'b1;
      #1;
      sb.delete();
      exp_ev = 0;
      check("rst.valid", rec_valid, 0);
      check("rst.lead", rec_lead, 0);
      check("rst.peak", rec_peak_gain, 0);
      check("rst.active", rec_active, 0);
      check("rst.flags", rec_flags, 0);
      check("rst.event_count", event_count, 0);
      check("rst.drop_count", drop_count, 0);
      check("rst.seq_error", seq_error, 0);
      ignition_phase = 3'd0;
      gain_envelope  = '0;
      plv_envelope   = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      sb.push_back('{90, 16384, 480, 0});
      run_event(100, 50, 50, 200, 80, 40, 40, 130, 1000, 16384);
      exp_ev++;
      drain_one("post_rst", 1'b0);
      repeat (10) @(posedge clk);
      #1;
      check("post_rst.single_record", rec_valid, 0);
      check("post_rst.event_count", event_count, exp_ev);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
